// File: rtl/panel_cmd_pkg.sv
// Shared definitions for the LED panel command protocol: opcodes, protocol bytes,
// panel geometry and the opcode-to-first-byte encoding.
package panel_cmd_pkg;

  localparam logic [2:0] OP_SET_RGB      = 3'd0;
  localparam logic [2:0] OP_SET_PIXEL    = 3'd1;
  localparam logic [2:0] OP_CLEAR_PIXEL  = 3'd2;
  localparam logic [2:0] OP_CLEAR_SCREEN = 3'd3;
  localparam logic [2:0] OP_RESYNC       = 3'd4;

  localparam logic [7:0] CMD_SET_RGB      = 8'h00;
  localparam logic [7:0] CMD_SET_PIXEL    = 8'h10;
  localparam logic [7:0] CMD_CLEAR_PIXEL  = 8'h20;
  localparam logic [7:0] CMD_CLEAR_SCREEN = 8'h30;
  localparam logic [7:0] CMD_RESYNC       = 8'hF5;

  localparam int PANEL_COLS = 16;
  localparam int PANEL_ROWS = 8;
  localparam int COL_W      = $clog2(PANEL_COLS);
  localparam int ROW_W      = $clog2(PANEL_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2,
    ST_BYTE2 = 2'd3
  } seq_state_t;

  function automatic logic [7:0] first_byte(input logic [2:0] op, input logic [2:0] rgb);
    case (op)
      OP_SET_RGB:      first_byte = CMD_SET_RGB | {5'b00000, rgb};
      OP_SET_PIXEL:    first_byte = CMD_SET_PIXEL;
      OP_CLEAR_PIXEL:  first_byte = CMD_CLEAR_PIXEL;
      OP_CLEAR_SCREEN: first_byte = CMD_CLEAR_SCREEN;
      OP_RESYNC:       first_byte = CMD_RESYNC;
      default:         first_byte = 8'h00;
    endcase
  endfunction

  function automatic logic is_pixel_op(input logic [2:0] op);
    return (op == OP_SET_PIXEL) || (op == OP_CLEAR_PIXEL);
  endfunction

  function automatic logic is_reserved_op(input logic [2:0] op);
    return op > OP_RESYNC;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serialiser. A start strobe is taken while idle or in the last clock of a
// stop bit, so consecutive bytes can be sent with no idle bits between them.
module uart_tx #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    IDX_STOP = 4'd9;

  logic [9:0]    frame_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    idx_r;
  logic          active_r;
  logic          tx_r;
  logic          done_r;
  logic          bit_end;
  logic          frame_end;
  logic          load;

  // Bit and frame boundary decode, and when a new byte may be loaded.
  always_comb begin
    bit_end   = active_r && (cnt_r == CNT_LAST);
    frame_end = bit_end && (idx_r == IDX_STOP);
    load      = start && (!active_r || frame_end);
  end

  // Frame shifter, bit timer and the done pulse registered one clock early so it
  // lands in the final clock of the stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_r  <= 10'h3FF;
      cnt_r    <= '0;
      idx_r    <= 4'd0;
      active_r <= 1'b0;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      done_r <= active_r && (idx_r == IDX_STOP) && (cnt_r == CNT_PRE);
      if (load) begin
        frame_r  <= {1'b1, data, 1'b0};
        tx_r     <= 1'b0;
        cnt_r    <= '0;
        idx_r    <= 4'd0;
        active_r <= 1'b1;
      end else if (frame_end) begin
        tx_r     <= 1'b1;
        cnt_r    <= '0;
        idx_r    <= 4'd0;
        active_r <= 1'b0;
      end else if (bit_end) begin
        cnt_r <= '0;
        idx_r <= idx_r + 4'd1;
        tx_r  <= frame_r[idx_r + 4'd1];
      end else if (active_r) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        tx_r <= 1'b1;
      end
    end
  end

  assign tx   = tx_r;
  assign done = done_r;
  assign busy = active_r;

endmodule

// File: rtl/panel_cmd_tx.sv
// Host-side LED panel command transmitter: takes one command per handshake, encodes
// it into 1-3 protocol bytes and sends them back-to-back on the UART line.
module panel_cmd_tx
  import panel_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_rgb,
  input  logic [3:0] cmd_col,
  input  logic [2:0] cmd_row,
  output logic       uart_tx_out,
  output logic       byte_done_out,
  output logic       busy_out
);

  seq_state_t       state_r;
  logic             ready_r;
  logic             pixel_r;
  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic             accept;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_done;
  logic             tx_busy;

  // The first byte goes straight from the command inputs so the start bit begins
  // on the acceptance edge; follow-on bytes are loaded on the previous byte's done.
  always_comb begin
    accept   = (state_r == ST_IDLE) && ready_r && cmd_valid && !tx_busy;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    if (accept) begin
      tx_start = !is_reserved_op(cmd_op);
      tx_data  = first_byte(cmd_op, cmd_rgb);
    end else if (tx_done && (state_r == ST_BYTE0) && pixel_r) begin
      tx_start = 1'b1;
      tx_data  = {4'h0, col_r};
    end else if (tx_done && (state_r == ST_BYTE1)) begin
      tx_start = 1'b1;
      tx_data  = {5'h00, row_r};
    end else begin
      tx_start = 1'b0;
      tx_data  = 8'h00;
    end
  end

  // Command sequencer; cmd_ready is raised on the last byte's done edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      pixel_r <= 1'b0;
      col_r   <= '0;
      row_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept) begin
            ready_r <= 1'b0;
            pixel_r <= is_pixel_op(cmd_op);
            col_r   <= cmd_col;
            row_r   <= cmd_row;
            state_r <= is_reserved_op(cmd_op) ? ST_IDLE : ST_BYTE0;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_BYTE0: begin
          if (tx_done) begin
            if (pixel_r) begin
              state_r <= ST_BYTE1;
            end else begin
              state_r <= ST_IDLE;
              ready_r <= 1'b1;
            end
          end
        end
        ST_BYTE1: begin
          if (tx_done) begin
            state_r <= ST_BYTE2;
          end
        end
        ST_BYTE2: begin
          if (tx_done) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (tx_data),
    .tx    (uart_tx_out),
    .done  (tx_done),
    .busy  (tx_busy)
  );

  assign cmd_ready     = ready_r;
  assign busy_out      = ~ready_r;
  assign byte_done_out = tx_done;

endmodule

// File: tb/tb_panel_cmd_tx.sv
// Directed bench for panel_cmd_tx: cycle-exact line/done/ready traces against
// hand-computed frames, plus a software 8N1 receiver decoding the sampled line.
module tb_panel_cmd_tx;
  import panel_cmd_pkg::*;

  localparam int C     = 20;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [2:0] cmd_rgb = 3'd0;
  logic [3:0] cmd_col = 4'd0;
  logic [2:0] cmd_row = 3'd0;
  logic       uart_tx_out;
  logic       byte_done_out;
  logic       busy_out;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  panel_cmd_tx #(.CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_rgb       (cmd_rgb),
    .cmd_col       (cmd_col),
    .cmd_row       (cmd_row),
    .uart_tx_out   (uart_tx_out),
    .byte_done_out (byte_done_out),
    .busy_out      (busy_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad = 0;
    repeat (n) begin
      tick();
      if (uart_tx_out !== 1'b1 || byte_done_out !== 1'b0 || cmd_ready !== 1'b1 || busy_out !== 1'b0)
        bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  // Sample j is taken 1 time unit after the j-th edge following the acceptance edge.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rgb, input logic [3:0] col,
                         input logic [2:0] row, input int nb, input logic [23:0] bytes,
                         input bit scramble, input bit hold, input logic [2:0] next_op,
                         input string tag);
    int w = 0;
    int total, b, base;
    int le = 0, de = 0, re = 0, ndone = 0, ferr = 0;
    logic line_q[$];
    logic [23:0] sh;
    logic [9:0] fr;
    logic [7:0] dec;
    logic exp_line, exp_done, exp_rdy;
    while (cmd_ready !== 1'b1 && w < 2000) begin
      tick();
      w++;
    end
    chk({tag, "_ready_wait"}, 32'(cmd_ready), 32'd1);
    if (cmd_ready !== 1'b1) return;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_rgb = rgb;
    cmd_col = col;
    cmd_row = row;
    tick();
    if (hold) cmd_op = next_op;
    else cmd_valid = 1'b0;
    total = nb * FRAME;
    for (int j = 0; j <= total; j++) begin
      if (j < total) begin
        b = j / FRAME;
        sh = bytes >> (8 * b);
        fr = {1'b1, sh[7:0], 1'b0};
        exp_line = fr[(j % FRAME) / C];
        exp_done = ((j % FRAME) == FRAME - 1);
        exp_rdy = 1'b0;
      end else begin
        exp_line = 1'b1;
        exp_done = 1'b0;
        exp_rdy = 1'b1;
      end
      if (uart_tx_out !== exp_line) le++;
      if (byte_done_out !== exp_done) de++;
      if (cmd_ready !== exp_rdy || busy_out !== !exp_rdy) re++;
      if (byte_done_out === 1'b1) ndone++;
      line_q.push_back(uart_tx_out);
      if (scramble) begin
        cmd_col = 4'($urandom);
        cmd_row = 3'($urandom);
      end
      if (j < total) tick();
    end
    chk({tag, "_line_trace"}, 32'(le), 32'd0);
    chk({tag, "_done_trace"}, 32'(de), 32'd0);
    chk({tag, "_ready_trace"}, 32'(re), 32'd0);
    chk({tag, "_done_count"}, 32'(ndone), 32'(nb));
    for (int bi = 0; bi < nb; bi++) begin
      base = bi * FRAME + C / 2;
      if (line_q[base] !== 1'b0 || line_q[base + 9 * C] !== 1'b1) ferr++;
      for (int i = 0; i < 8; i++) dec[i] = line_q[base + (i + 1) * C];
      sh = bytes >> (8 * bi);
      chk($sformatf("%s_rx_byte%0d", tag, bi), 32'(dec), 32'(sh[7:0]));
    end
    chk({tag, "_framing"}, 32'(ferr), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (5) tick();
    chk("rst_hold_line", 32'(uart_tx_out), 32'd1);
    reset = 1'b0;
    tick();
    chk("rst_line", 32'(uart_tx_out), 32'd1);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(byte_done_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    idle_check("rst_idle", 100);

    run_cmd(OP_SET_RGB, 3'b101, 4'd0, 3'd0, 1, 24'h000005, 1'b0, 1'b0, 3'd0, "set_rgb5");
    run_cmd(OP_SET_PIXEL, 3'd0, 4'd9, 3'd6, 3, 24'h060910, 1'b0, 1'b0, 3'd0, "set_pix");
    run_cmd(OP_RESYNC, 3'd0, 4'd0, 3'd0, 1, 24'h0000F5, 1'b0, 1'b1, OP_CLEAR_SCREEN, "resync");
    run_cmd(OP_CLEAR_SCREEN, 3'd0, 4'd0, 3'd0, 1, 24'h000030, 1'b0, 1'b0, 3'd0, "clr_scr");

    cmd_valid = 1'b1;
    cmd_op = 3'd6;
    tick();
    chk("rsv_ready_low", 32'(cmd_ready), 32'd0);
    chk("rsv_line", 32'(uart_tx_out), 32'd1);
    cmd_valid = 1'b0;
    tick();
    chk("rsv_ready_back", 32'(cmd_ready), 32'd1);
    idle_check("rsv_idle", 40);

    // Reset in the middle of the column byte of CLEAR_PIXEL col=5 row=3.
    cmd_valid = 1'b1;
    cmd_op = OP_CLEAR_PIXEL;
    cmd_col = 4'd5;
    cmd_row = 3'd3;
    tick();
    cmd_valid = 1'b0;
    repeat (FRAME + 5 * C) tick();
    chk("cp_mid_ready", 32'(cmd_ready), 32'd0);
    chk("cp_mid_line", 32'(uart_tx_out), 32'd0);
    reset = 1'b1;
    tick();
    chk("cp_rst_line", 32'(uart_tx_out), 32'd1);
    chk("cp_rst_ready", 32'(cmd_ready), 32'd1);
    chk("cp_rst_busy", 32'(busy_out), 32'd0);
    chk("cp_rst_done", 32'(byte_done_out), 32'd0);
    reset = 1'b0;
    idle_check("cp_no_residual", 3 * FRAME);
    run_cmd(OP_SET_RGB, 3'b010, 4'd0, 3'd0, 1, 24'h000002, 1'b0, 1'b0, 3'd0, "set_rgb2");

    run_cmd(OP_SET_PIXEL, 3'd0, 4'd12, 3'd7, 3, 24'h070C10, 1'b1, 1'b0, 3'd0, "scr_pix");
    run_cmd(OP_CLEAR_PIXEL, 3'd0, 4'd15, 3'd0, 3, 24'h000F20, 1'b1, 1'b0, 3'd0, "scr_clr");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/panel_cmd_tx.md
Name: panel_cmd_tx

Overview:
Host-side transmitter for the LED panel UART command protocol. It accepts one abstract command per handshake: set colour, set pixel, clear pixel, clear screen or resync. It encodes the command into 1–3 protocol bytes and serialises them 8N1 on a single UART line. It sits in test/companion logic driving the panel's uart_data input, so it is the sending end of the panel's command receiver.

Parameters:
CLKS_PER_BIT, 20, clocks per UART bit; must match the panel receiver; legal range 2..255.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  command request.
cmd_ready  output  1  block can accept a command.
cmd_op  input  3  0=SET_RGB, 1=SET_PIXEL, 2=CLEAR_PIXEL, 3=CLEAR_SCREEN, 4=RESYNC, 5..7 reserved.
cmd_rgb  input  3  colour {r,g,b}; used by SET_RGB only.
cmd_col  input  4  pixel column 0..15.
cmd_row  input  3  pixel row 0..7.
uart_tx_out  output  1  serial line; idles high.
byte_done_out  output  1  one-cycle pulse at the end of each transmitted stop bit.
busy_out  output  1  equals ~cmd_ready.

Behaviour:
- Reset (synchronous, clk, reset=1): uart_tx_out=1, cmd_ready=1, busy_out=0, byte_done_out=0, sequencer=IDLE, bit counters cleared. Reset mid-byte forces the line high at the next edge and drops the command in progress. No partial-byte completion.
- Handshake: accept on a posedge with cmd_valid & cmd_ready. All cmd_* fields are latched at that edge. cmd_ready is high only in IDLE and drops the cycle after acceptance.
- Byte encodings:
  - SET_RGB -> {5'b00000, rgb}.
  - SET_PIXEL -> 0x10, {4'h0,col}, {5'h0,row}.
  - CLEAR_PIXEL -> 0x20, col byte, row byte.
  - CLEAR_SCREEN -> 0x30.
  - RESYNC -> 0xF5.
  - Reserved ops: accepted, zero bytes sent, cmd_ready high again the next cycle.
- Sequencer states: IDLE -> BYTE0 -> (BYTE1 -> BYTE2 for pixel ops) -> IDLE.
  - Each BYTEn state loads the serialiser and waits for its done pulse.
  - 1-byte ops return to IDLE from BYTE0.
- Serialiser frame: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT clocks, so a byte is 10*CLKS_PER_BIT clocks.
- Timing (acceptance edge = E0, N = byte count, C = CLKS_PER_BIT):
  - uart_tx_out goes low at E0+1.
  - Bytes within one command are back-to-back, with no idle bits between stop and next start.
  - byte_done_out pulses in the last clock of each stop bit.
  - cmd_ready returns high at E0+N*10*C+1.
  - A command accepted at that edge starts its start bit one clock later. This gives exactly one idle-high clock between commands.
- cmd_valid held high continuously: commands are accepted at each IDLE opportunity only; no acceptance occurs while busy.
- cmd_* changes while busy have no effect on the bytes in flight.
- Counter widths: bit-time counter is ceil(log2(CLKS_PER_BIT)) bits and wraps to 0 at C-1. Bit index is 4 bits, 0..9.

Decomposition:
- Shared package panel_cmd_pkg holds:
  - opcode constants OP_SET_RGB..OP_RESYNC.
  - protocol byte constants CMD_SET_RGB=0x00, CMD_SET_PIXEL=0x10, CMD_CLEAR_PIXEL=0x20, CMD_CLEAR_SCREEN=0x30, CMD_RESYNC=0xF5.
  - PANEL_COLS=16, PANEL_ROWS=8.
- One sub-module, uart_tx: byte in, start strobe, serial out, done pulse, busy. It is parameterised by CLKS_PER_BIT and reusable as the mirror of the existing uart_rx.

Test Plan:
- Reset held 5 clocks, then released -> uart_tx_out=1, cmd_ready=1, byte_done_out=0; no line activity for 100 clocks.
- SET_RGB rgb=3'b101, C=20 -> line carries 0x05 LSB first (bit pattern 0,1,0,1,0,0,0,0,0,1 per 20 clocks); one byte_done_out pulse; cmd_ready high at E0+201.
- SET_PIXEL col=9 row=6 -> bytes 0x10,0x09,0x06 back-to-back with no gap; 3 byte_done pulses; busy for 600 clocks. A bench uart_rx at the same C decodes all three bytes.
- cmd_valid held high with RESYNC then CLEAR_SCREEN -> 0xF5 then 0x30, separated by exactly one idle-high clock. Reserved op 6 -> no line activity, cmd_ready low for exactly 1 cycle.
- Reset asserted mid-way through the second byte of CLEAR_PIXEL -> line high at the next edge, cmd_ready=1. A new SET_RGB afterwards transmits correctly, and no residual row byte appears.
- Change cmd_col/cmd_row every cycle while busy -> transmitted col/row bytes equal the values latched at the acceptance edge.
